// File: rtl/range_display.sv
// Latches a rangefinder result, converts it to BCD with a sequential double-dabble
// engine and scans it onto a 4-digit multiplexed 7-segment display with an error LED.
module range_display #(
  parameter int WIDTH       = 16,
  parameter int REFRESH_DIV = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] range_in,
  input  logic             error_in,
  input  logic             update,
  output logic             busy,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             err_led
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);
  localparam logic [CW-1:0] REF_LAST  = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_bin;
  logic [19:0]      r_bcd;
  logic [IW-1:0]    r_iter;
  logic             r_errLatch;
  logic [15:0]      r_dispDigits;
  logic             r_dispErr;
  logic [CW-1:0]    r_refCnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic [15:0]      w_bcdAdj;
  logic [15:0]      w_loadDigits;
  logic [1:0]       w_idxNext;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [6:0]       w_segNext;

  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0:    segOf = 7'h3F;
      4'd1:    segOf = 7'h06;
      4'd2:    segOf = 7'h5B;
      4'd3:    segOf = 7'h4F;
      4'd4:    segOf = 7'h66;
      4'd5:    segOf = 7'h6D;
      4'd6:    segOf = 7'h7D;
      4'd7:    segOf = 7'h07;
      4'd8:    segOf = 7'h7F;
      4'd9:    segOf = 7'h6F;
      default: segOf = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    busy        = 1'b0;
    case (r_state)
      IDLE:    if (update) w_stateNext = CONVERT;
      CONVERT: begin
        busy = 1'b1;
        if (r_iter == ITER_LAST) w_stateNext = LOAD;
      end
      LOAD: begin
        busy        = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Digit 4 can never reach 5 before the final shift, so only digits 0-3 are adjusted.
  always_comb begin
    w_bcdAdj = r_bcd[15:0];
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcdAdj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
    w_loadDigits = (r_bcd[19:16] != 4'd0) ? 16'h9999 : r_bcd[15:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bin        <= '0;
      r_bcd        <= '0;
      r_iter       <= '0;
      r_errLatch   <= 1'b0;
      r_dispDigits <= '0;
      r_dispErr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (update) begin
          r_bin      <= range_in;
          r_errLatch <= error_in;
          r_bcd      <= '0;
          r_iter     <= '0;
        end
        CONVERT: begin
          r_bcd  <= {r_bcd[18:16], w_bcdAdj, r_bin[WIDTH-1]};
          r_bin  <= {r_bin[WIDTH-2:0], 1'b0};
          r_iter <= r_iter + 1'b1;
        end
        LOAD: begin
          r_dispDigits <= w_loadDigits;
          r_dispErr    <= r_errLatch;
        end
        default: ;
      endcase
    end
  end

  // Segment pattern is computed for the index about to be shown so seg and an move together.
  always_comb begin
    w_idxNext = (r_refCnt == REF_LAST) ? r_idx + 2'd1 : r_idx;
    w_digit   = r_dispDigits[{w_idxNext, 2'b00} +: 4];
    case (w_idxNext)
      2'd1:    w_blank = (r_dispDigits[15:4]  == 12'd0);
      2'd2:    w_blank = (r_dispDigits[15:8]  == 8'd0);
      2'd3:    w_blank = (r_dispDigits[15:12] == 4'd0);
      default: w_blank = 1'b0;
    endcase
    if (r_dispErr)    w_segNext = 7'h40;
    else if (w_blank) w_segNext = 7'h00;
    else              w_segNext = segOf(w_digit);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_refCnt <= '0;
      r_idx    <= 2'd0;
      r_an     <= 4'b0001;
      r_seg    <= 7'h3F;
    end else begin
      r_refCnt <= (r_refCnt == REF_LAST) ? '0 : r_refCnt + 1'b1;
      r_idx    <= w_idxNext;
      r_an     <= 4'b0001 << w_idxNext;
      r_seg    <= w_segNext;
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign err_led = r_dispErr;

endmodule

// File: tb/tb_range_display.sv
// Directed bench for range_display: reset state, scan rotation, BCD conversion,
// saturation, error dashes, ignored updates while busy and reset mid-conversion.
module tb_range_display;

  localparam int WIDTH       = 16;
  localparam int REFRESH_DIV = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] range_in;
  logic             error_in;
  logic             update;
  logic             busy;
  logic [6:0]       seg;
  logic [3:0]       an;
  logic             err_led;

  int checkCount = 0;
  int passCount  = 0;

  range_display #(.WIDTH(WIDTH), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .range_in (range_in),
    .error_in (error_in),
    .update   (update),
    .busy     (busy),
    .seg      (seg),
    .an       (an),
    .err_led  (err_led)
  );

  always #5 clock = ~clock;

  // One comparison: counts it, and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for a digit to be enabled, then checks its segment pattern.
  task automatic readDigit(input string tag, input int idx, input logic [6:0] expected);
    int waitCycles;
    logic [3:0] wantAn;
    waitCycles = 0;
    wantAn = 4'(1 << idx);
    while (an !== wantAn && waitCycles < 40) begin
      @(negedge clock);
      waitCycles++;
    end
    checkOutput($sformatf("%s an%0d", tag, idx), 32'(an), 32'(wantAn));
    checkOutput($sformatf("%s seg%0d", tag, idx), 32'(seg), 32'(expected));
  endtask

  task automatic checkDigits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    readDigit(tag, 0, e0);
    readDigit(tag, 1, e1);
    readDigit(tag, 2, e2);
    readDigit(tag, 3, e3);
  endtask

  // Pulses update for one edge; returns at the negedge just after that edge.
  task automatic applyStimulus(input logic [15:0] value, input logic err);
    @(negedge clock);
    range_in = value;
    error_in = err;
    update   = 1'b1;
    @(negedge clock);
    update   = 1'b0;
  endtask

  // Counts busy cycles (bounded), then waits one more cycle for seg to reflect LOAD.
  task automatic waitIdle(input string tag);
    int busyCycles;
    busyCycles = 0;
    while (busy && busyCycles < 100) begin
      busyCycles++;
      @(negedge clock);
    end
    checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'd17);
    @(negedge clock);
  endtask

  initial begin
    int cyc;
    reset    = 1'b1;
    range_in = '0;
    error_in = 1'b0;
    update   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    checkOutput("reset an", 32'(an), 32'h1);
    checkOutput("reset seg", 32'(seg), 32'h3F);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset err_led", 32'(err_led), 32'h0);
    repeat (3) @(negedge clock);
    checkOutput("scan hold an", 32'(an), 32'h1);
    @(negedge clock);
    checkOutput("scan step an", 32'(an), 32'h2);
    checkOutput("scan step seg", 32'(seg), 32'h00);
    checkDigits("zero", 7'h3F, 7'h00, 7'h00, 7'h00);

    applyStimulus(16'd1234, 1'b0);
    checkOutput("1234 busy rises", 32'(busy), 32'h1);
    waitIdle("1234");
    checkDigits("1234", 7'h66, 7'h4F, 7'h5B, 7'h06);

    applyStimulus(16'd42, 1'b0);
    waitIdle("42");
    checkDigits("42", 7'h5B, 7'h66, 7'h00, 7'h00);

    applyStimulus(16'd0, 1'b0);
    waitIdle("0");
    checkDigits("0", 7'h3F, 7'h00, 7'h00, 7'h00);

    applyStimulus(16'd40000, 1'b0);
    waitIdle("40000");
    checkDigits("40000", 7'h6F, 7'h6F, 7'h6F, 7'h6F);
    checkOutput("40000 err_led", 32'(err_led), 32'h0);

    applyStimulus(16'd65535, 1'b0);
    waitIdle("65535");
    checkDigits("65535", 7'h6F, 7'h6F, 7'h6F, 7'h6F);

    applyStimulus(16'd7, 1'b1);
    waitIdle("err7");
    checkOutput("err7 err_led", 32'(err_led), 32'h1);
    checkDigits("err7", 7'h40, 7'h40, 7'h40, 7'h40);

    applyStimulus(16'd5, 1'b0);
    waitIdle("5");
    checkOutput("5 err_led", 32'(err_led), 32'h0);
    checkDigits("5", 7'h6D, 7'h00, 7'h00, 7'h00);

    // Updates at conversion cycles 3 and 5 must neither restart nor replace the value.
    applyStimulus(16'd1234, 1'b0);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (cyc == 3 || cyc == 5) begin
        range_in = 16'd777;
        update   = 1'b1;
      end else begin
        update   = 1'b0;
      end
      @(negedge clock);
    end
    update = 1'b0;
    checkOutput("ignore busy cycles", 32'(cyc), 32'd17);
    @(negedge clock);
    checkDigits("ignore", 7'h66, 7'h4F, 7'h5B, 7'h06);

    applyStimulus(16'd4321, 1'b0);
    repeat (7) @(negedge clock);
    checkOutput("abort busy before reset", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort busy", 32'(busy), 32'h0);
    checkOutput("abort an", 32'(an), 32'h1);
    checkOutput("abort seg", 32'(seg), 32'h3F);
    checkOutput("abort err_led", 32'(err_led), 32'h0);
    cyc = 0;
    repeat (30) begin
      @(negedge clock);
      if (busy) cyc++;
    end
    checkOutput("abort no load busy", 32'(cyc), 32'd0);
    checkDigits("abort", 7'h3F, 7'h00, 7'h00, 7'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
